holdem_card_dealer: RTL and testbench

//   Stimulus/front-end stage for the 9-player win-rate calculator.

---
 rtl/holdem_card_dealer_if.sv | 24 ++
 rtl/holdem_card_dealer.sv | 131 +++++++++++++
 tb/tb_holdem_card_dealer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/holdem_card_dealer_if.sv
// Handshake and deal-payload bundle between the card dealer and its neighbours.
// The out_* packing matches the win-rate calculator's in_hole_*/in_pub_* ports.
interface holdem_card_dealer_if;
  logic        in_seed_valid;
  logic [15:0] in_seed;
  logic        in_start;
  logic        in_ready;
  logic        out_busy;
  logic        out_valid;
  logic [71:0] out_hole_num;
  logic [35:0] out_hole_suit;
  logic [11:0] out_pub_num;
  logic [5:0]  out_pub_suit;

  modport master (
    output in_seed_valid, in_seed, in_start, in_ready,
    input  out_busy, out_valid, out_hole_num, out_hole_suit, out_pub_num, out_pub_suit
  );

  modport slave (
    input  in_seed_valid, in_seed, in_start, in_ready,
    output out_busy, out_valid, out_hole_num, out_hole_suit, out_pub_num, out_pub_suit
  );
endinterface

// File: rtl/holdem_card_dealer.sv
// Deals 21 distinct cards (18 hole, 3 public) from a Galois LFSR with duplicate
// rejection, then emits the deal as a single-cycle pulse once downstream is ready.
module holdem_card_dealer #(
  parameter int unsigned       LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
) (
  input logic                  clk,
  input logic                  rst,
  holdem_card_dealer_if.slave  bus
);

  localparam int unsigned N_SLOTS = 21;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned N_PLAY  = 9;
  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(16'hB400);

  typedef enum logic [1:0] {IDLE, DRAW, WAIT, EMIT} state_t;

  state_t             state;
  logic [LFSR_W-1:0]  lfsr;
  logic [63:0]        mask;
  logic [CNT_W-1:0]   count;
  logic [3:0]         slot_num  [N_SLOTS];
  logic [1:0]         slot_suit [N_SLOTS];

  logic [5:0]         cand_c;
  logic               accept_c;
  logic [5:0]         base_c;
  logic [1:0]         suit_c;
  logic [3:0]         num_c;
  logic [LFSR_W-1:0]  lfsr_next_c;
  logic [71:0]        hole_num_c;
  logic [35:0]        hole_suit_c;
  logic [11:0]        pub_num_c;
  logic [5:0]         pub_suit_c;

  // Candidate card, its rank/suit decode, and the LFSR step.
  always_comb begin
    cand_c      = lfsr[5:0];
    accept_c    = (cand_c < 6'd52) && !mask[cand_c];
    suit_c      = 2'd0;
    base_c      = 6'd0;
    if (cand_c >= 6'd39) begin
      suit_c = 2'd3;
      base_c = 6'd39;
    end else if (cand_c >= 6'd26) begin
      suit_c = 2'd2;
      base_c = 6'd26;
    end else if (cand_c >= 6'd13) begin
      suit_c = 2'd1;
      base_c = 6'd13;
    end
    num_c       = 4'(cand_c - base_c) + 4'd1;
    lfsr_next_c = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
  end

  // Slots are filled player 8 first, so player p owns slots 2*(8-p) and 2*(8-p)+1.
  always_comb begin
    hole_num_c  = '0;
    hole_suit_c = '0;
    for (int p = 0; p < int'(N_PLAY); p++) begin
      hole_num_c[p*8+4 +: 4]  = slot_num[2*(8-p)];
      hole_num_c[p*8 +: 4]    = slot_num[2*(8-p)+1];
      hole_suit_c[p*4+2 +: 2] = slot_suit[2*(8-p)];
      hole_suit_c[p*4 +: 2]   = slot_suit[2*(8-p)+1];
    end
    pub_num_c  = {slot_num[18], slot_num[19], slot_num[20]};
    pub_suit_c = {slot_suit[18], slot_suit[19], slot_suit[20]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      lfsr               <= SEED;
      mask               <= '0;
      count              <= '0;
      bus.out_busy       <= 1'b0;
      bus.out_valid      <= 1'b0;
      bus.out_hole_num   <= '0;
      bus.out_hole_suit  <= '0;
      bus.out_pub_num    <= '0;
      bus.out_pub_suit   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Seed load precedes start so the first DRAW cycle uses the new value.
          if (bus.in_seed_valid) begin
            lfsr <= (bus.in_seed == 16'd0) ? SEED : LFSR_W'(bus.in_seed);
          end
          if (bus.in_start) begin
            state        <= DRAW;
            mask         <= '0;
            count        <= '0;
            bus.out_busy <= 1'b1;
          end
        end
        DRAW: begin
          lfsr <= lfsr_next_c;
          if (accept_c) begin
            mask[cand_c]     <= 1'b1;
            slot_num[count]  <= num_c;
            slot_suit[count] <= suit_c;
            count            <= count + CNT_W'(1);
            if (count == CNT_W'(N_SLOTS - 1)) state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.in_ready) begin
            state             <= EMIT;
            bus.out_valid     <= 1'b1;
            bus.out_hole_num  <= hole_num_c;
            bus.out_hole_suit <= hole_suit_c;
            bus.out_pub_num   <= pub_num_c;
            bus.out_pub_suit  <= pub_suit_c;
          end
        end
        EMIT: begin
          state              <= IDLE;
          bus.out_busy       <= 1'b0;
          bus.out_valid      <= 1'b0;
          bus.out_hole_num   <= '0;
          bus.out_hole_suit  <= '0;
          bus.out_pub_num    <= '0;
          bus.out_pub_suit   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_holdem_card_dealer.sv
// Directed bench for holdem_card_dealer: reference dealing model, determinism,
// ignore-while-busy, backpressure, abort and a long uniqueness run.
module tb_holdem_card_dealer;

  typedef struct packed {
    logic [71:0] hn;
    logic [35:0] hs;
    logic [11:0] pn;
    logic [5:0]  ps;
  } deal_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  holdem_card_dealer_if bus();
  holdem_card_dealer dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] m_lf;
  deal_t first_exp;
  deal_t last_obs;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic deal_t observed();
    return {bus.out_hole_num, bus.out_hole_suit, bus.out_pub_num, bus.out_pub_suit};
  endfunction

  // Reference dealer: walks the LFSR sequence and lays cards out by player index.
  function automatic void model(input logic [15:0] seed, output logic [15:0] lf_out,
                                output deal_t d, output int draws);
    int card [21];
    bit used [52];
    int cnt;
    logic [15:0] lf;
    for (int i = 0; i < 52; i++) used[i] = 1'b0;
    for (int i = 0; i < 21; i++) card[i] = 0;
    lf = seed;
    cnt = 0;
    draws = 0;
    while (cnt < 21 && draws < 100000) begin
      int c;
      c = int'(lf[5:0]);
      draws++;
      if (c < 52 && !used[c]) begin
        used[c] = 1'b1;
        card[cnt] = c;
        cnt++;
      end
      lf = lf[0] ? ((lf >> 1) ^ 16'hB400) : (lf >> 1);
    end
    lf_out = lf;
    d = '0;
    for (int p = 0; p < 9; p++) begin
      d.hn[p*8+4 +: 4] = 4'(card[16-2*p] % 13 + 1);
      d.hn[p*8 +: 4]   = 4'(card[17-2*p] % 13 + 1);
      d.hs[p*4+2 +: 2] = 2'(card[16-2*p] / 13);
      d.hs[p*4 +: 2]   = 2'(card[17-2*p] / 13);
    end
    for (int j = 0; j < 3; j++) begin
      d.pn[(2-j)*4 +: 4] = 4'(card[18+j] % 13 + 1);
      d.ps[(2-j)*2 +: 2] = 2'(card[18+j] / 13);
    end
  endfunction

  // Structural sanity of a deal independent of the reference model.
  function automatic bit deal_ok(input deal_t d);
    bit seen [52];
    int n, s, k;
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < 52; i++) seen[i] = 1'b0;
    for (int i = 0; i < 21; i++) begin
      if (i < 18) begin
        n = int'(d.hn[i*4 +: 4]);
        s = int'(d.hs[i*2 +: 2]);
      end else begin
        n = int'(d.pn[(i-18)*4 +: 4]);
        s = int'(d.ps[(i-18)*2 +: 2]);
      end
      if (n < 1 || n > 13) ok = 1'b0;
      else begin
        k = s * 13 + n - 1;
        if (seen[k]) ok = 1'b0;
        seen[k] = 1'b1;
      end
    end
    return ok;
  endfunction

  // One full deal with in_ready held high; optional seed load alongside start
  // and an optional start/seed pulse injected mid-DRAW.
  task automatic run_deal(input string tag, input bit load_seed, input logic [15:0] seed,
                          input bit pulse, input bit full_checks);
    logic [15:0] nxt;
    deal_t exp;
    int draws;
    int cyc;
    if (load_seed) m_lf = (seed == 16'd0) ? 16'hACE1 : seed;
    model(m_lf, nxt, exp, draws);
    @(negedge clk);
    bus.in_start      = 1'b1;
    bus.in_seed_valid = load_seed;
    bus.in_seed       = seed;
    @(negedge clk);
    bus.in_start      = 1'b0;
    bus.in_seed_valid = 1'b0;
    if (full_checks) chk({tag, "_busy_hi"}, 128'(bus.out_busy), 128'(1));
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (pulse && cyc == 3) begin
        bus.in_start      = 1'b1;
        bus.in_seed_valid = 1'b1;
        bus.in_seed       = 16'h1234;
      end else begin
        bus.in_start      = 1'b0;
        bus.in_seed_valid = 1'b0;
      end
    end while (!bus.out_valid && cyc < 2000);
    last_obs = observed();
    if (full_checks) chk({tag, "_latency"}, 128'(cyc), 128'(draws + 1));
    else chk({tag, "_lat_bound"}, 128'(cyc < 1000), 128'(1));
    chk({tag, "_deal"}, 128'(last_obs), 128'(exp));
    if (full_checks) begin
      chk({tag, "_ok"}, 128'(deal_ok(last_obs)), 128'(1));
      @(negedge clk);
      chk({tag, "_valid_lo"}, 128'(bus.out_valid), 128'(0));
      chk({tag, "_busy_lo"}, 128'(bus.out_busy), 128'(0));
      chk({tag, "_data_lo"}, 128'(observed()), 128'(0));
    end else begin
      chk({tag, "_ok"}, 128'(deal_ok(last_obs)), 128'(1));
    end
    m_lf = nxt;
  endtask

  initial begin
    logic [15:0] nxt;
    deal_t exp;
    deal_t d2;
    int draws;
    bit seen_valid;

    rst               = 1'b1;
    bus.in_seed_valid = 1'b0;
    bus.in_seed       = 16'h0000;
    bus.in_start      = 1'b0;
    bus.in_ready      = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_busy", 128'(bus.out_busy), 128'(0));
    chk("rst_hole_num", 128'(bus.out_hole_num), 128'(0));
    chk("rst_hole_suit", 128'(bus.out_hole_suit), 128'(0));
    chk("rst_pub", 128'({bus.out_pub_num, bus.out_pub_suit}), 128'(0));
    chk("rst_lfsr", 128'(dut.lfsr), 128'(16'hACE1));

    // Deal from the reset seed, then a follow-on deal continuing the sequence.
    m_lf = 16'hACE1;
    model(m_lf, nxt, first_exp, draws);
    run_deal("deal1", 1'b0, 16'h0, 1'b0, 1'b1);
    run_deal("deal2", 1'b0, 16'h0, 1'b0, 1'b1);
    d2 = last_obs;
    chk("deal2_differs", 128'(d2 != first_exp), 128'(1));

    // Zero seed falls back to the default seed.
    @(negedge clk);
    bus.in_seed_valid = 1'b1;
    bus.in_seed       = 16'h0000;
    @(negedge clk);
    bus.in_seed_valid = 1'b0;
    m_lf = 16'hACE1;
    run_deal("seed0", 1'b0, 16'h0, 1'b0, 1'b1);
    chk("seed0_eq_first", 128'(last_obs), 128'(first_exp));

    // Seed and start together: first DRAW uses the new seed.
    run_deal("seed1234", 1'b1, 16'h1234, 1'b0, 1'b1);

    // Start/seed pulse while busy has no effect on this or the next deal.
    run_deal("ignore", 1'b0, 16'h0, 1'b1, 1'b1);
    run_deal("after_ignore", 1'b0, 16'h0, 1'b0, 1'b1);

    // Backpressure: hold in_ready low well past the end of DRAW.
    bus.in_ready = 1'b0;
    model(m_lf, nxt, exp, draws);
    @(negedge clk);
    bus.in_start = 1'b1;
    @(negedge clk);
    bus.in_start = 1'b0;
    seen_valid = 1'b0;
    repeat (draws + 50) begin
      @(negedge clk);
      if (bus.out_valid) seen_valid = 1'b1;
    end
    chk("bp_no_valid", 128'(seen_valid), 128'(0));
    chk("bp_busy", 128'(bus.out_busy), 128'(1));
    bus.in_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_t1", 128'(bus.out_valid), 128'(1));
    chk("bp_deal", 128'(observed()), 128'(exp));
    @(negedge clk);
    chk("bp_valid_t2", 128'(bus.out_valid), 128'(0));
    m_lf = nxt;

    // Long run of back-to-back deals.
    for (int i = 0; i < 1000; i++) run_deal("bulk", 1'b0, 16'h0, 1'b0, 1'b0);

    // Abort on the 5th DRAW cycle, then redeal from the reset seed.
    @(negedge clk);
    bus.in_start = 1'b1;
    @(negedge clk);
    bus.in_start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 128'(bus.out_busy), 128'(0));
    chk("abort_valid", 128'(bus.out_valid), 128'(0));
    chk("abort_data", 128'(observed()), 128'(0));
    m_lf = 16'hACE1;
    run_deal("post_abort", 1'b0, 16'h0, 1'b0, 1'b1);
    chk("post_abort_eq_first", 128'(last_obs), 128'(first_exp));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
